ucie_ctl_sb_rx_msg_decoder: RTL and testbench

Receive-side counterpart of the sideband TX message builder.
- Accepts inbound sideband packets as 32-bit phases from the SB deserializer.
- Checks header/data parity and classifies opcode/msgcode/msgsubcode into the 5-bit RDI sideband decode code.
- Presents the code, plus 64-bit advertised-capability data, to the CTL FSM over a valid/ack handshake.

---
 rtl/ucie_ctl_sb_pkg.sv | 54 +++++
 rtl/ucie_ctl_sb_rx_msg_decoder_classifier.sv | 57 +++++
 rtl/ucie_ctl_sb_rx_msg_decoder.sv | 166 ++++++++++++++++
 tb/tb_ucie_ctl_sb_rx_msg_decoder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucie_ctl_sb_pkg.sv
// Shared sideband constants: opcodes, msgcodes, subcodes, RDI decode codes,
// header bit positions and the RX decoder FSM state type.
package ucie_ctl_sb_pkg;

  localparam logic [4:0] OPC_MSG_NODATA = 5'b10010;
  localparam logic [4:0] OPC_MSG_DATA64 = 5'b11011;

  // MC_ADV_CAP and MC_LM_REQ share a value; the opcode disambiguates them.
  localparam logic [7:0] MC_ADV_CAP = 8'h01;
  localparam logic [7:0] MC_LM_REQ  = 8'h01;
  localparam logic [7:0] MC_LM_RSP  = 8'h02;
  localparam logic [7:0] MC_ERROR   = 8'h09;

  localparam logic [7:0] SC_ADV_CAP      = 8'h00;
  localparam logic [7:0] SC_ACTIVE       = 8'h01;
  localparam logic [7:0] SC_LINK_RESET   = 8'h09;
  localparam logic [7:0] SC_ERR_CORR     = 8'h00;
  localparam logic [7:0] SC_ERR_NONFATAL = 8'h01;
  localparam logic [7:0] SC_ERR_FATAL    = 8'h02;

  localparam logic [4:0] DC_ADV_CAP        = 5'b00000;
  localparam logic [4:0] DC_REQ_ACTIVE     = 5'b10101;
  localparam logic [4:0] DC_REQ_LINK_RESET = 5'b10111;
  localparam logic [4:0] DC_RSP_ACTIVE     = 5'b11001;
  localparam logic [4:0] DC_RSP_LINK_RESET = 5'b11011;
  localparam logic [4:0] DC_ERR_CORR       = 5'b11100;
  localparam logic [4:0] DC_ERR_NONFATAL   = 5'b11101;
  localparam logic [4:0] DC_ERR_FATAL      = 5'b11110;

  // Phase0 field positions
  localparam int HDR_OPC_LSB   = 0;
  localparam int HDR_OPC_MSB   = 4;
  localparam int HDR_MC_LSB    = 14;
  localparam int HDR_MC_MSB    = 21;
  localparam int HDR_SRC_LSB   = 27;
  localparam int HDR_SRC_MSB   = 29;
  localparam int HDR_CP_BIT    = 30;
  localparam int HDR_DP_BIT    = 31;
  // Phase1 field positions
  localparam int HDR_SC_LSB    = 0;
  localparam int HDR_SC_MSB    = 7;
  localparam int HDR_INFO_LSB  = 8;
  localparam int HDR_INFO_MSB  = 23;
  localparam int HDR_DST_LSB   = 24;
  localparam int HDR_DST_MSB   = 26;

  typedef enum logic [1:0] {
    S_HDR0  = 2'd0,
    S_HDR1  = 2'd1,
    S_DATA0 = 2'd2,
    S_DATA1 = 2'd3
  } sb_rx_state_e;

endpackage

// File: rtl/ucie_ctl_sb_rx_msg_decoder_classifier.sv
// Pure combinational lookup of (opcode, msgcode, subcode) to {known, code}.
module ucie_ctl_sb_rx_classifier
  import ucie_ctl_sb_pkg::*;
(
  input  logic [4:0] i_opcode,
  input  logic [7:0] i_msgcode,
  input  logic [7:0] i_subcode,
  output logic       o_known,
  output logic [4:0] o_code
);

  always_comb begin
    o_known = 1'b0;
    o_code  = DC_ADV_CAP;
    if (i_opcode == OPC_MSG_DATA64) begin
      if (i_msgcode == MC_ADV_CAP && i_subcode == SC_ADV_CAP) begin
        o_known = 1'b1;
        o_code  = DC_ADV_CAP;
      end
    end else if (i_opcode == OPC_MSG_NODATA) begin
      case (i_msgcode)
        MC_LM_REQ: begin
          if (i_subcode == SC_ACTIVE) begin
            o_known = 1'b1;
            o_code  = DC_REQ_ACTIVE;
          end else if (i_subcode == SC_LINK_RESET) begin
            o_known = 1'b1;
            o_code  = DC_REQ_LINK_RESET;
          end
        end
        MC_LM_RSP: begin
          if (i_subcode == SC_ACTIVE) begin
            o_known = 1'b1;
            o_code  = DC_RSP_ACTIVE;
          end else if (i_subcode == SC_LINK_RESET) begin
            o_known = 1'b1;
            o_code  = DC_RSP_LINK_RESET;
          end
        end
        MC_ERROR: begin
          if (i_subcode == SC_ERR_CORR) begin
            o_known = 1'b1;
            o_code  = DC_ERR_CORR;
          end else if (i_subcode == SC_ERR_NONFATAL) begin
            o_known = 1'b1;
            o_code  = DC_ERR_NONFATAL;
          end else if (i_subcode == SC_ERR_FATAL) begin
            o_known = 1'b1;
            o_code  = DC_ERR_FATAL;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ucie_ctl_sb_rx_msg_decoder.sv
// Sideband RX decoder: assembles header/data phases, checks parity, classifies
// the message and reports it to the CTL FSM over a valid/ack handshake.
module ucie_ctl_sb_rx_msg_decoder
  import ucie_ctl_sb_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int PHASE_W = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic               i_sb_rx_valid,
  input  logic [PHASE_W-1:0] i_sb_rx_data,
  input  logic               i_ctl_ack,
  output logic [4:0]         o_rdi_pl_sb_decode,
  output logic               o_rdi_pl_sb_valid,
  output logic [DATA_W-1:0]  o_adv_cap_data,
  output logic               o_unknown_msg,
  output logic               o_parity_err,
  output logic               o_overrun
);

  // Handshake: a report is offered while o_rdi_pl_sb_valid is 1 and is
  // consumed on any cycle where valid and i_ctl_ack are both 1.

  sb_rx_state_e       state_q, state_d;
  logic [PHASE_W-1:0] hdr0_q, hdr0_d;
  logic [PHASE_W-1:0] hdr1_q, hdr1_d;
  logic [PHASE_W-1:0] data_lo_q, data_lo_d;

  logic [4:0]         decode_q, decode_d;
  logic               valid_q, valid_d;
  logic [DATA_W-1:0]  adv_cap_q, adv_cap_d;
  logic               unknown_q, unknown_d;
  logic               parity_err_q, parity_err_d;
  logic               overrun_q, overrun_d;

  logic               accept;
  logic               eval_fire;
  logic               is_data_msg;
  logic [PHASE_W-1:0] phase1_cur;
  logic [DATA_W-1:0]  data_full;
  logic [4:0]         opcode;
  logic               cp_calc;
  logic               dp_calc;
  logic               parity_ok;
  logic               cls_known;
  logic [4:0]         cls_code;
  logic               good_msg;

  assign accept = i_enable && i_sb_rx_valid;
  assign opcode = hdr0_q[HDR_OPC_MSB:HDR_OPC_LSB];

  // Phase1 is still on the bus when a no-data message completes.
  assign phase1_cur  = (state_q == S_HDR1) ? i_sb_rx_data : hdr1_q;
  assign data_full   = {i_sb_rx_data, data_lo_q};
  assign is_data_msg = (state_q == S_DATA1);

  assign cp_calc   = ^{hdr0_q[HDR_SRC_MSB:0], phase1_cur};
  assign dp_calc   = is_data_msg ? ^data_full : 1'b0;
  assign parity_ok = (hdr0_q[HDR_CP_BIT] == cp_calc) && (hdr0_q[HDR_DP_BIT] == dp_calc);

  ucie_ctl_sb_rx_classifier u_classifier (
    .i_opcode  (opcode),
    .i_msgcode (hdr0_q[HDR_MC_MSB:HDR_MC_LSB]),
    .i_subcode (phase1_cur[HDR_SC_MSB:HDR_SC_LSB]),
    .o_known   (cls_known),
    .o_code    (cls_code)
  );

  always_comb begin
    state_d   = state_q;
    hdr0_d    = hdr0_q;
    hdr1_d    = hdr1_q;
    data_lo_d = data_lo_q;
    eval_fire = 1'b0;
    if (!i_enable) begin
      state_d = S_HDR0;
    end else if (accept) begin
      unique case (state_q)
        S_HDR0: begin
          hdr0_d  = i_sb_rx_data;
          state_d = S_HDR1;
        end
        S_HDR1: begin
          hdr1_d = i_sb_rx_data;
          if (opcode == OPC_MSG_DATA64) begin
            state_d = S_DATA0;
          end else begin
            state_d   = S_HDR0;
            eval_fire = 1'b1;
          end
        end
        S_DATA0: begin
          data_lo_d = i_sb_rx_data;
          state_d   = S_DATA1;
        end
        S_DATA1: begin
          state_d   = S_HDR0;
          eval_fire = 1'b1;
        end
        default: state_d = S_HDR0;
      endcase
    end
  end

  assign good_msg = eval_fire && parity_ok && cls_known;

  always_comb begin
    decode_d     = decode_q;
    valid_d      = valid_q;
    adv_cap_d    = adv_cap_q;
    unknown_d    = eval_fire && parity_ok && !cls_known;
    parity_err_d = eval_fire && !parity_ok;
    overrun_d    = 1'b0;
    if (valid_q && i_ctl_ack) begin
      valid_d = 1'b0;
    end
    if (good_msg) begin
      // An ack in the same cycle frees the slot for the new report.
      if (valid_q && !i_ctl_ack) begin
        overrun_d = 1'b1;
      end else begin
        decode_d = cls_code;
        valid_d  = 1'b1;
        if (cls_code == DC_ADV_CAP) begin
          adv_cap_d = data_full;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= S_HDR0;
      hdr0_q       <= '0;
      hdr1_q       <= '0;
      data_lo_q    <= '0;
      decode_q     <= '0;
      valid_q      <= 1'b0;
      adv_cap_q    <= '0;
      unknown_q    <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hdr0_q       <= hdr0_d;
      hdr1_q       <= hdr1_d;
      data_lo_q    <= data_lo_d;
      decode_q     <= decode_d;
      valid_q      <= valid_d;
      adv_cap_q    <= adv_cap_d;
      unknown_q    <= unknown_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign o_rdi_pl_sb_decode = decode_q;
  assign o_rdi_pl_sb_valid  = valid_q;
  assign o_adv_cap_data     = adv_cap_q;
  assign o_unknown_msg      = unknown_q;
  assign o_parity_err       = parity_err_q;
  assign o_overrun          = overrun_q;

endmodule

// File: tb/tb_ucie_ctl_sb_rx_msg_decoder.sv
// Randomized bench for the sideband RX decoder, checked against a
// table-driven message model and a pending-report scoreboard.
module tb_ucie_ctl_sb_rx_msg_decoder;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_enable;
  logic        i_sb_rx_valid;
  logic [31:0] i_sb_rx_data;
  logic        i_ctl_ack;
  logic [4:0]  o_rdi_pl_sb_decode;
  logic        o_rdi_pl_sb_valid;
  logic [63:0] o_adv_cap_data;
  logic        o_unknown_msg;
  logic        o_parity_err;
  logic        o_overrun;

  ucie_ctl_sb_rx_msg_decoder dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_enable           (i_enable),
    .i_sb_rx_valid      (i_sb_rx_valid),
    .i_sb_rx_data       (i_sb_rx_data),
    .i_ctl_ack          (i_ctl_ack),
    .o_rdi_pl_sb_decode (o_rdi_pl_sb_decode),
    .o_rdi_pl_sb_valid  (o_rdi_pl_sb_valid),
    .o_adv_cap_data     (o_adv_cap_data),
    .o_unknown_msg      (o_unknown_msg),
    .o_parity_err       (o_parity_err),
    .o_overrun          (o_overrun)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [4:0] opc;
    logic [7:0] mc;
    logic [7:0] sc;
    logic [4:0] code;
  } ent_t;

  ent_t        tbl [8];
  logic [4:0]  exp_q [$];   // report offered to CTL, at most one entry
  logic [4:0]  m_code;      // last loaded decode value
  logic [63:0] m_adv;
  int          n_checks = 0;
  int          n_fail   = 0;

  localparam logic [4:0] NODATA = 5'b10010;
  localparam logic [4:0] DATA64 = 5'b11011;

  function automatic void lookup(input logic [4:0] opc, input logic [7:0] mc,
                                 input logic [7:0] sc, output bit known,
                                 output logic [4:0] code);
    known = 1'b0;
    code  = 5'd0;
    foreach (tbl[i]) begin
      if (tbl[i].opc == opc && tbl[i].mc == mc && tbl[i].sc == sc) begin
        known = 1'b1;
        code  = tbl[i].code;
      end
    end
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_code = 5'd0;
    m_adv  = 64'd0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic make_phases(input logic [4:0] opc, input logic [7:0] mc, input logic [7:0] sc,
                             input logic [63:0] data, output logic [31:0] ph [4]);
    ph[0] = $urandom;
    ph[1] = $urandom;
    ph[0][4:0]   = opc;
    ph[0][21:14] = mc;
    ph[1][7:0]   = sc;
    ph[0][30]    = ^{ph[0][29:0], ph[1]};
    ph[0][31]    = (opc == DATA64) ? ^data : 1'b0;
    ph[2]        = data[31:0];
    ph[3]        = data[63:32];
  endtask

  task automatic drive_phase(input logic [31:0] d, input bit ack);
    i_sb_rx_valid = 1'b1;
    i_sb_rx_data  = d;
    i_ctl_ack     = ack;
    @(posedge i_clk);
    #1;
    i_sb_rx_valid = 1'b0;
    i_sb_rx_data  = $urandom;
    i_ctl_ack     = 1'b0;
  endtask

  task automatic do_ack();
    i_ctl_ack = 1'b1;
    idle_cycle();
    i_ctl_ack = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    check_eq("ack.valid", {63'd0, o_rdi_pl_sb_valid}, 64'd0);
    check_eq("ack.decode", {59'd0, o_rdi_pl_sb_decode}, {59'd0, m_code});
  endtask

  // Send one packet (optionally with one flipped bit) and check the outcome.
  task automatic run_pkt(input string tag, input logic [4:0] opc, input logic [7:0] mc,
                         input logic [7:0] sc, input logic [63:0] data, input int flip,
                         input bit ack_last);
    logic [31:0] ph [4];
    logic [4:0]  code;
    bit          known, pend, exp_ovr, exp_par, exp_unk;
    int          n;
    make_phases(opc, mc, sc, data, ph);
    if (flip >= 0) ph[flip / 32][flip % 32] = ~ph[flip / 32][flip % 32];
    n = (opc == DATA64) ? 4 : 2;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) idle_cycle();
      drive_phase(ph[i], ack_last && (i == n - 1));
    end
    lookup(opc, mc, sc, known, code);
    exp_par = (flip >= 0);
    exp_unk = !exp_par && !known;
    exp_ovr = 1'b0;
    pend    = (exp_q.size() != 0);
    if (ack_last && pend) void'(exp_q.pop_front());
    if (!exp_par && known) begin
      if (pend && !ack_last) begin
        exp_ovr = 1'b1;
      end else begin
        exp_q.push_back(code);
        m_code = code;
        if (code == 5'b00000) m_adv = data;
      end
    end
    check_eq({tag, ".parity_err"}, {63'd0, o_parity_err}, {63'd0, exp_par});
    check_eq({tag, ".unknown"}, {63'd0, o_unknown_msg}, {63'd0, exp_unk});
    check_eq({tag, ".overrun"}, {63'd0, o_overrun}, {63'd0, exp_ovr});
    check_eq({tag, ".valid"}, {63'd0, o_rdi_pl_sb_valid}, {63'd0, exp_q.size() != 0});
    check_eq({tag, ".decode"}, {59'd0, o_rdi_pl_sb_decode}, {59'd0, m_code});
    check_eq({tag, ".adv_cap"}, o_adv_cap_data, m_adv);
    idle_cycle();
    check_eq({tag, ".pulses_clear"}, {61'd0, o_parity_err, o_unknown_msg, o_overrun}, 64'd0);
    check_eq({tag, ".valid_hold"}, {63'd0, o_rdi_pl_sb_valid}, {63'd0, exp_q.size() != 0});
  endtask

  task automatic clear_pending();
    if (exp_q.size() != 0) do_ack();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".decode"}, {59'd0, o_rdi_pl_sb_decode}, 64'd0);
    check_eq({tag, ".valid"}, {63'd0, o_rdi_pl_sb_valid}, 64'd0);
    check_eq({tag, ".adv_cap"}, o_adv_cap_data, 64'd0);
    check_eq({tag, ".pulses"}, {61'd0, o_parity_err, o_unknown_msg, o_overrun}, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] ph [4];
    logic [7:0]  mc_pool [4];
    logic [7:0]  sc_pool [6];
    int          kind, total;

    tbl[0] = '{DATA64, 8'h01, 8'h00, 5'b00000};
    tbl[1] = '{NODATA, 8'h01, 8'h01, 5'b10101};
    tbl[2] = '{NODATA, 8'h01, 8'h09, 5'b10111};
    tbl[3] = '{NODATA, 8'h02, 8'h01, 5'b11001};
    tbl[4] = '{NODATA, 8'h02, 8'h09, 5'b11011};
    tbl[5] = '{NODATA, 8'h09, 8'h00, 5'b11100};
    tbl[6] = '{NODATA, 8'h09, 8'h01, 5'b11101};
    tbl[7] = '{NODATA, 8'h09, 8'h02, 5'b11110};
    mc_pool = '{8'h01, 8'h02, 8'h09, 8'h00};
    sc_pool = '{8'h00, 8'h01, 8'h02, 8'h09, 8'h05, 8'h00};
    model_reset();

    i_rst = 1'b0;
    i_enable = 1'b1;
    i_sb_rx_valid = 1'b0;
    i_sb_rx_data = 32'd0;
    i_ctl_ack = 1'b0;
    repeat (3) idle_cycle();
    check_all_zero("reset");
    i_rst = 1'b1;
    idle_cycle();

    // Directed scenarios
    run_pkt("lm_req_active", NODATA, 8'h01, 8'h01, 64'd0, -1, 1'b0);
    do_ack();
    run_pkt("adv_cap", DATA64, 8'h01, 8'h00, 64'h00000001_DEADBEEF, -1, 1'b0);
    do_ack();
    run_pkt("err_fatal_flip", NODATA, 8'h09, 8'h02, 64'd0, 32 + 3, 1'b0);
    run_pkt("err_unknown_sc", NODATA, 8'h09, 8'h05, 64'd0, -1, 1'b0);
    run_pkt("err_corr", NODATA, 8'h09, 8'h00, 64'd0, -1, 1'b0);
    run_pkt("overrun", NODATA, 8'h02, 8'h09, 64'd0, -1, 1'b0);
    run_pkt("ack_same_cycle", NODATA, 8'h02, 8'h09, 64'd0, -1, 1'b1);
    do_ack();

    // Abort after phase0; a phase offered while disabled must be ignored.
    make_phases(NODATA, 8'h01, 8'h09, 64'd0, ph);
    drive_phase(ph[0], 1'b0);
    i_enable = 1'b0;
    drive_phase(ph[1], 1'b0);
    idle_cycle();
    check_eq("disabled.valid", {63'd0, o_rdi_pl_sb_valid}, 64'd0);
    check_eq("disabled.pulses", {61'd0, o_parity_err, o_unknown_msg, o_overrun}, 64'd0);
    i_enable = 1'b1;
    run_pkt("after_enable", NODATA, 8'h01, 8'h09, 64'd0, -1, 1'b0);

    // Reset while in the last data phase with a report pending.
    make_phases(DATA64, 8'h01, 8'h00, 64'h12345678_9ABCDEF0, ph);
    for (int i = 0; i < 3; i++) drive_phase(ph[i], 1'b0);
    i_sb_rx_valid = 1'b1;
    i_sb_rx_data  = ph[3];
    #2;
    i_rst = 1'b0;
    #1;
    check_all_zero("mid_rst");
    i_sb_rx_valid = 1'b0;
    model_reset();
    idle_cycle();
    i_rst = 1'b1;
    idle_cycle();
    run_pkt("post_rst", DATA64, 8'h01, 8'h00, {$urandom, $urandom}, -1, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 150; t++) begin
      if (exp_q.size() != 0 && $urandom_range(0, 2) == 0) do_ack();
      kind = $urandom_range(0, 9);
      if (kind < 8) begin
        run_pkt("rand_good", tbl[kind].opc, tbl[kind].mc, tbl[kind].sc,
                {$urandom, $urandom}, -1, $urandom_range(0, 3) == 0);
      end else if (kind == 8) begin
        logic [4:0] opc;
        case ($urandom_range(0, 2))
          0:       opc = NODATA;
          1:       opc = DATA64;
          default: opc = 5'($urandom);
        endcase
        run_pkt("rand_any", opc, mc_pool[$urandom_range(0, 3)], sc_pool[$urandom_range(0, 5)],
                {$urandom, $urandom}, -1, $urandom_range(0, 3) == 0);
      end else begin
        int k;
        k = $urandom_range(0, 7);
        total = (tbl[k].opc == DATA64) ? 128 : 64;
        run_pkt("rand_parity", tbl[k].opc, tbl[k].mc, tbl[k].sc,
                {$urandom, $urandom}, $urandom_range(5, total - 1), $urandom_range(0, 3) == 0);
      end
    end
    clear_pending();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
